// File: rtl/pe_controller.sv
// Processing-element controller: loads a 2^L_RAM_SIZE-word vector from a synchronous-read
// RAM into a local buffer, then MACs its lower half against its upper half.
module pe_controller #(
    parameter int VECTOR_SIZE = 32,
    parameter int L_RAM_SIZE  = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    output logic                   done,
    output logic [L_RAM_SIZE-1:0]  rdaddr,
    input  logic [VECTOR_SIZE-1:0] rddata,
    output logic [VECTOR_SIZE-1:0] wrdata
);

    localparam int N  = 1 << L_RAM_SIZE;
    localparam int CW = L_RAM_SIZE + 1;
    localparam logic [L_RAM_SIZE-1:0] LAST_A   = L_RAM_SIZE'(N - 1);
    localparam logic [L_RAM_SIZE-1:0] HALF_A   = L_RAM_SIZE'(N / 2);
    localparam logic [L_RAM_SIZE-1:0] CALC_END = L_RAM_SIZE'(N / 2 - 1);
    localparam logic [CW-1:0]         LOAD_END = CW'(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DONE
    } state_t;

    state_t                         state_q;
    logic                           done_q;
    logic [L_RAM_SIZE-1:0]          rdaddr_q;
    logic signed [VECTOR_SIZE-1:0]  wrdata_q;
    logic signed [VECTOR_SIZE-1:0]  acc_q;
    logic signed [VECTOR_SIZE-1:0]  acc_d;
    logic [CW-1:0]                  load_cnt_q;
    logic [L_RAM_SIZE-1:0]          calc_cnt_q;
    logic                           vld_p0;
    logic                           vld_p1;
    logic [L_RAM_SIZE-1:0]          addr_p1;
    logic signed [VECTOR_SIZE-1:0]  buf_q [N];

    // Products and sums keep only the low VECTOR_SIZE bits (two's-complement wrap).
    function automatic logic signed [VECTOR_SIZE-1:0] mac_wrap(
        input logic signed [VECTOR_SIZE-1:0] acc,
        input logic signed [VECTOR_SIZE-1:0] a,
        input logic signed [VECTOR_SIZE-1:0] b
    );
        logic signed [VECTOR_SIZE-1:0] prod_lo;
        prod_lo = a * b;
        return acc + prod_lo;
    endfunction

    always_comb begin
        acc_d = mac_wrap(acc_q, buf_q[calc_cnt_q], buf_q[calc_cnt_q + HALF_A]);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            rdaddr_q   <= '0;
            wrdata_q   <= '0;
            acc_q      <= '0;
            load_cnt_q <= '0;
            calc_cnt_q <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rdaddr_q <= '0;
                    vld_p0   <= 1'b0;
                    if (start) begin
                        state_q    <= S_LOAD;
                        acc_q      <= '0;
                        load_cnt_q <= '0;
                        vld_p0     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    load_cnt_q <= load_cnt_q + 1'b1;
                    if (rdaddr_q != LAST_A) begin
                        rdaddr_q <= rdaddr_q + 1'b1;
                        vld_p0   <= 1'b1;
                    end else begin
                        vld_p0   <= 1'b0;
                    end
                    // Leave only after the last word has landed in the buffer.
                    if (load_cnt_q == LOAD_END) begin
                        state_q    <= S_CALC;
                        rdaddr_q   <= '0;
                        calc_cnt_q <= '0;
                    end
                end
                S_CALC: begin
                    acc_q      <= acc_d;
                    calc_cnt_q <= calc_cnt_q + 1'b1;
                    if (calc_cnt_q == CALC_END) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    wrdata_q <= acc_q;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stage p1: address that was on rdaddr last cycle; its data is on rddata now.
    always_ff @(posedge aclk) begin
        addr_p1 <= rdaddr_q;
        if (vld_p1) begin
            buf_q[addr_p1] <= rddata;
        end
    end

    assign done   = done_q;
    assign rdaddr = rdaddr_q;
    assign wrdata = wrdata_q;

endmodule

// File: tb/tb_pe_controller.sv
// Directed bench for pe_controller: vector table of memory fills with hand-computed
// dot products, plus sequences for busy start, abort and back-to-back runs.
module tb_pe_controller;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        done;
    logic [3:0]  rdaddr;
    logic [31:0] rddata;
    logic [31:0] wrdata;

    logic [31:0] mem [16];

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       name;
        logic [31:0] lo_base;
        logic [31:0] lo_step;
        logic [31:0] hi_base;
        logic [31:0] hi_step;
        int          sp_idx;
        logic [31:0] sp_val;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    pe_controller #(32, 4) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .start   (start),
        .done    (done),
        .rdaddr  (rdaddr),
        .rddata  (rddata),
        .wrdata  (wrdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) rddata <= mem[rdaddr];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            if (i < 8) mem[i] = v.lo_base + v.lo_step * 32'(i);
            else       mem[i] = v.hi_base + v.hi_step * 32'(i - 8);
            if (v.sp_idx == i) mem[i] = v.sp_val;
        end
    endtask

    task automatic run_check(input vec_t v, input int restart_k);
        int          done_k;
        int          pulses;
        logic        seq_ok;
        logic [3:0]  exp_a;
        load_mem(v);
        @(negedge aclk);
        start = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        start  = 1'b0;
        done_k = -1;
        pulses = 0;
        seq_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (k == restart_k)     start = 1'b1;
            if (k == restart_k + 1) start = 1'b0;
            if (k < 16)      exp_a = 4'(k);
            else if (k < 18) exp_a = 4'd15;
            else             exp_a = 4'd0;
            if (rdaddr !== exp_a) seq_ok = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (done_k < 0) done_k = k;
            end
            @(negedge aclk);
        end
        check({v.name, " latency"}, 64'(done_k), 64'd27);
        check({v.name, " done_pulses"}, 64'(pulses), 64'd1);
        check({v.name, " rdaddr_seq"}, 64'(seq_ok), 64'd1);
        check({v.name, " wrdata"}, 64'(wrdata), 64'(v.exp));
    endtask

    initial begin
        int first_k;
        int second_k;
        int pulses;
        logic [31:0] w1;
        logic [31:0] w2;

        vecs[0] = '{"ramp",    32'd1,          32'd1, 32'd9,          32'd1, -1, 32'd0,          32'h0000_01EC};
        vecs[1] = '{"neg_x3",  32'hFFFF_FFFF,  32'd0, 32'd3,          32'd0, -1, 32'd0,          32'hFFFF_FFE8};
        vecs[2] = '{"wrap",    32'd0,          32'd0, 32'd2,          32'd0,  0, 32'h8000_0000,  32'h0000_0000};
        vecs[3] = '{"maxpos",  32'h7FFF_FFFF,  32'd0, 32'h7FFF_FFFF,  32'd0, -1, 32'd0,          32'h0000_0008};
        vecs[4] = '{"neg_neg", 32'hFFFF_FFFE,  32'd0, 32'hFFFF_FFFB,  32'd0, -1, 32'd0,          32'h0000_0050};
        vecs[5] = '{"last_lo", 32'd0,          32'd0, 32'hFFFF_FFF9,  32'd0,  7, 32'd100,        32'hFFFF_FD44};
        vecs[6] = '{"last_hi", 32'd5,          32'd0, 32'd0,          32'd0, 15, 32'd11,         32'h0000_0037};

        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        aresetn = 1'b0;
        start   = 1'b1;

        @(negedge aclk);
        @(negedge aclk);
        check("reset done", 64'(done), 64'd0);
        check("reset rdaddr", 64'(rdaddr), 64'd0);
        check("reset wrdata", 64'(wrdata), 64'd0);
        start   = 1'b0;
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        check("idle rdaddr", 64'(rdaddr), 64'd0);
        check("idle done", 64'(done), 64'd0);

        for (int vi = 0; vi < 7; vi++) run_check(vecs[vi], -5);

        run_check(vecs[0], 5);

        // Abort during CALC: wrdata still holds 492 from the previous run.
        load_mem(vecs[6]);
        @(negedge aclk);
        start = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        start  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) pulses++;
            @(negedge aclk);
        end
        check("abort pre wrdata", 64'(wrdata), 64'h1EC);
        aresetn = 1'b0;
        #1;
        check("abort done", 64'(done), 64'd0);
        check("abort rdaddr", 64'(rdaddr), 64'd0);
        check("abort wrdata", 64'(wrdata), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) pulses++;
            @(negedge aclk);
        end
        check("abort no_done", 64'(pulses), 64'd0);
        check("abort wrdata_held", 64'(wrdata), 64'd0);
        run_check(vecs[0], -5);

        // start held high: consecutive runs.
        load_mem(vecs[0]);
        @(negedge aclk);
        start = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        first_k  = -1;
        second_k = -1;
        w1 = 32'd0;
        w2 = 32'd0;
        for (int k = 0; k < 60; k++) begin
            if (done === 1'b1) begin
                if (first_k < 0) begin
                    first_k = k;
                    w1 = wrdata;
                end else if (second_k < 0) begin
                    second_k = k;
                    w2 = wrdata;
                end
            end
            @(negedge aclk);
        end
        start = 1'b0;
        check("b2b first", 64'(first_k), 64'd27);
        check("b2b spacing", 64'(second_k - first_k), 64'd28);
        check("b2b wrdata1", 64'(w1), 64'h1EC);
        check("b2b wrdata2", 64'(w2), 64'h1EC);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
